// File: rtl/coupler_n_if.sv
// rtl/coupler_n_if.sv - record-in / word-out bus of the coupler_n packer
interface coupler_n_if #(
    parameter int P_WIDTH = 256,
    parameter int RATIO   = 4
) ();
    logic [P_WIDTH-1:0]       i_data;
    logic                     i_enq;
    logic                     o_full;
    logic [RATIO*P_WIDTH-1:0] o_data;
    logic                     i_deq;
    logic                     o_empty;

    modport master (output i_data, i_enq, i_deq, input o_full, o_data, o_empty);
    modport slave  (input i_data, i_enq, i_deq, output o_full, o_data, o_empty);
endinterface

// File: rtl/coupler_n.sv
// rtl/coupler_n.sv - packs RATIO records into one wide word; COUPLER_ZERO_TERM_EN enables zero-record stream termination
module coupler_n #(
    parameter int P_WIDTH   = 256,
    parameter int RATIO     = 4,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    coupler_n_if.slave bus
);
    localparam int W   = RATIO * P_WIDTH;
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int SW  = $clog2(RATIO);

    logic [P_WIDTH-1:0] in_mem_q [IN_DEPTH];
    logic [IAW:0]       in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [W-1:0]       out_mem_q [OUT_DEPTH];
    logic [OAW:0]       out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [P_WIDTH-1:0] pack_q [RATIO];
    logic [P_WIDTH-1:0] pack_d [RATIO];

`ifdef COUPLER_ZERO_TERM_EN
    typedef enum logic {FILL, TERM} state_t;
    state_t state_q, state_d;
    logic   rec_zero;
`endif

    logic               in_full, in_empty, out_full, out_empty;
    logic               in_push, can_pop, close, term, out_pop;
    logic [P_WIDTH-1:0] head;
    logic [W-1:0]       out_word;

    always_comb begin
        in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
        in_empty  = (in_wr_q == in_rd_q);
        out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
        out_empty = (out_wr_q == out_rd_q);
        head      = in_mem_q[in_rd_q[IAW-1:0]];

`ifdef COUPLER_ZERO_TERM_EN
        rec_zero = (head == '0);
        can_pop  = !in_empty && !out_full && (state_q == FILL);
        term     = rec_zero;
`else
        can_pop  = !in_empty && !out_full;
        term     = 1'b0;
`endif
        close   = can_pop && ((slot_q == SW'(RATIO - 1)) || term);
        // A full input FIFO still takes a write when the packer frees a slot on the same edge.
        in_push = bus.i_enq && (!in_full || can_pop);
        out_pop = bus.i_deq && !out_empty;

        // Slots beyond the current one are zero, which pads terminated words for free.
        out_word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(slot_q))
                out_word[k*P_WIDTH +: P_WIDTH] = head;
            else if (k < int'(slot_q))
                out_word[k*P_WIDTH +: P_WIDTH] = pack_q[k];
        end

        pack_d = pack_q;
        slot_d = slot_q;
        if (can_pop) begin
            pack_d[slot_q] = head;
            slot_d = close ? '0 : slot_q + SW'(1);
        end

`ifdef COUPLER_ZERO_TERM_EN
        state_d = FILL;
        if (state_q == FILL && can_pop && rec_zero && slot_q != '0)
            state_d = TERM;
`endif

        in_wr_d  = in_wr_q + (IAW+1)'(in_push);
        in_rd_d  = in_rd_q + (IAW+1)'(can_pop);
        out_wr_d = out_wr_q + (OAW+1)'(close);
        out_rd_d = out_rd_q + (OAW+1)'(out_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            out_wr_q <= '0;
            out_rd_q <= '0;
            slot_q   <= '0;
            pack_q   <= '{default: '0};
`ifdef COUPLER_ZERO_TERM_EN
            state_q  <= FILL;
`endif
        end else begin
            in_wr_q  <= in_wr_d;
            in_rd_q  <= in_rd_d;
            out_wr_q <= out_wr_d;
            out_rd_q <= out_rd_d;
            slot_q   <= slot_d;
            pack_q   <= pack_d;
`ifdef COUPLER_ZERO_TERM_EN
            state_q  <= state_d;
`endif
            if (in_push)
                in_mem_q[in_wr_q[IAW-1:0]] <= bus.i_data;
            if (close)
                out_mem_q[out_wr_q[OAW-1:0]] <= out_word;
        end
    end

    assign bus.o_full  = in_full;
    assign bus.o_empty = out_empty;
    assign bus.o_data  = out_empty ? '0 : out_mem_q[out_rd_q[OAW-1:0]];
endmodule

// File: tb/tb_coupler_n.sv
// tb/tb_coupler_n.sv - directed self-checking bench for coupler_n (default and shallow-output instances)
module tb_coupler_n;
    localparam int P = 32;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coupler_n_if #(.P_WIDTH(P), .RATIO(R)) a ();
    coupler_n_if #(.P_WIDTH(P), .RATIO(R)) b ();

    coupler_n #(.P_WIDTH(P), .RATIO(R), .IN_DEPTH(16), .OUT_DEPTH(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(a.slave));
    coupler_n #(.P_WIDTH(P), .RATIO(R), .IN_DEPTH(16), .OUT_DEPTH(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b.slave));

    function automatic logic [127:0] mk(input logic [31:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic enq_a(input int v);
        a.i_data = 32'(v);
        a.i_enq  = 1'b1;
        tick();
        a.i_enq  = 1'b0;
    endtask

    task automatic enq_b(input int v);
        b.i_data = 32'(v);
        b.i_enq  = 1'b1;
        tick();
        b.i_enq  = 1'b0;
    endtask

    task automatic deq_a();
        a.i_deq = 1'b1;
        tick();
        a.i_deq = 1'b0;
    endtask

    task automatic get_word_b(input string tag, input logic [127:0] exp);
        int n = 0;
        while (b.o_empty && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_avail"}, b.o_empty, 0);
        chk(tag, b.o_data, exp);
        b.i_deq = 1'b1;
        tick();
        b.i_deq = 1'b0;
    endtask

    initial begin
        a.i_data = '0; a.i_enq = 1'b0; a.i_deq = 1'b0;
        b.i_data = '0; b.i_enq = 1'b0; b.i_deq = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_full", a.o_full, 0);
        chk("rst_empty", a.o_empty, 1);
        chk("rst_data", a.o_data, 0);
        chk("rst_empty_b", b.o_empty, 1);

        // fill one word
        for (int v = 1; v <= 4; v++) begin
            a.i_data = 32'(v);
            a.i_enq  = 1'b1;
            tick();
        end
        a.i_enq = 1'b0;
        chk("fill_lat_empty", a.o_empty, 1);
        tick();
        chk("fill_ready", a.o_empty, 0);
        chk("fill_word", a.o_data, mk(1, 2, 3, 4));
        deq_a();
        chk("fill_drained", a.o_empty, 1);

`ifdef COUPLER_ZERO_TERM_EN
        begin
            int recs [7] = '{5, 6, 0, 7, 8, 9, 10};
            for (int i = 0; i < 7; i++) begin
                a.i_data = 32'(recs[i]);
                a.i_enq  = 1'b1;
                tick();
            end
            a.i_enq = 1'b0;
        end
        chk("term_pad_word", a.o_data, mk(5, 6, 0, 0));
        deq_a();
        chk("term_bubble", a.o_empty, 1);
        tick();
        chk("term_next_ready", a.o_empty, 0);
        chk("term_next_word", a.o_data, mk(7, 8, 9, 10));
        deq_a();
        chk("term_drained", a.o_empty, 1);

        enq_a(0);
        enq_a(0);
        tick();
        chk("zrun_w1_ready", a.o_empty, 0);
        chk("zrun_w1_data", a.o_data, 0);
        deq_a();
        chk("zrun_w2_ready", a.o_empty, 0);
        chk("zrun_w2_data", a.o_data, 0);
        deq_a();
        chk("zrun_drained", a.o_empty, 1);
`else
        enq_a(5);
        enq_a(6);
        enq_a(0);
        enq_a(7);
        tick();
        chk("zdata_ready", a.o_empty, 0);
        chk("zdata_word", a.o_data, mk(5, 6, 0, 7));
        deq_a();
        chk("zdata_drained", a.o_empty, 1);

        for (int i = 0; i < 4; i++) enq_a(0);
        tick();
        chk("zrun_ready", a.o_empty, 0);
        chk("zrun_data", a.o_data, 0);
        deq_a();
        tick();
        chk("zrun_single", a.o_empty, 1);
`endif

        // reset mid-word
        enq_a(1);
        enq_a(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_empty", a.o_empty, 1);
        chk("midrst_data", a.o_data, 0);
        chk("midrst_full", a.o_full, 0);
        for (int v = 9; v <= 12; v++) enq_a(v);
        tick();
        chk("midrst_ready", a.o_empty, 0);
        chk("midrst_word", a.o_data, mk(9, 10, 11, 12));
        deq_a();
        tick();
        chk("midrst_only", a.o_empty, 1);

        // back-pressure on the 2-deep output instance
        for (int v = 1; v <= 12; v++) begin
            b.i_data = 32'(v);
            b.i_enq  = 1'b1;
            tick();
        end
        b.i_enq = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_full", b.o_full, 0);
        chk("bp_ready", b.o_empty, 0);
        chk("bp_w1", b.o_data, mk(1, 2, 3, 4));
        b.i_deq = 1'b1;
        tick();
        b.i_deq = 1'b0;
        chk("bp_w2", b.o_data, mk(5, 6, 7, 8));
        b.i_deq = 1'b1;
        tick();
        b.i_deq = 1'b0;
        get_word_b("bp_w3", mk(9, 10, 11, 12));
        tick();
        chk("bp_drained", b.o_empty, 1);

        // full input FIFO behind a stalled output FIFO
        for (int v = 1; v <= 23; v++) begin
            b.i_data = 32'(v);
            b.i_enq  = 1'b1;
            tick();
        end
        chk("full_before", b.o_full, 0);
        b.i_data = 32'(24);
        tick();
        chk("full_reached", b.o_full, 1);
        b.i_data = 32'(999);
        tick();
        tick();
        b.i_enq = 1'b0;
        chk("full_held", b.o_full, 1);
        b.i_deq = 1'b1;
        tick();
        b.i_deq = 1'b0;
        chk("full_after_deq", b.o_full, 1);
        enq_b(25);
        chk("full_simul", b.o_full, 1);
        get_word_b("full_w2", mk(5, 6, 7, 8));
        get_word_b("full_w3", mk(9, 10, 11, 12));
        get_word_b("full_w4", mk(13, 14, 15, 16));
        get_word_b("full_w5", mk(17, 18, 19, 20));
        get_word_b("full_w6", mk(21, 22, 23, 24));
        enq_b(26);
        enq_b(27);
        enq_b(28);
        get_word_b("full_w7", mk(25, 26, 27, 28));
        tick();
        chk("full_drained", b.o_empty, 1);
        chk("full_released", b.o_full, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
